// File: rtl/hazard_forward_ctrl.sv
// Decode-stage hazard controller: tracks EX/MEM destinations, registers the
// forwarding selects for the issuing instruction and raises load-use stalls.
module hazard_forward_ctrl #(
    parameter int REGW = 3,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs_a,
    input  logic [REGW-1:0] id_rs_b,
    input  logic            id_use_a,
    input  logic            id_use_b,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_wr,
    input  logic            id_load,
    input  logic            id_store,
    input  logic            flush,
    output logic            stall,
    output logic            one_a,
    output logic            one_b,
    output logic            two_a,
    output logic            two_b,
    output logic            mw_one,
    output logic            mw_two,
    output logic [CNTW-1:0] stall_count
);

    logic [REGW-1:0] ex_rd_q, ex_rd_d;
    logic            ex_wr_q, ex_wr_d;
    logic            ex_load_q, ex_load_d;
    logic [REGW-1:0] mem_rd_q;
    logic            mem_wr_q;

    logic one_a_q, one_a_d, two_a_q, two_a_d;
    logic one_b_q, one_b_d, two_b_q, two_b_d;
    logic mw_one_q, mw_one_d, mw_two_q, mw_two_d;
    logic [CNTW-1:0] count_q, count_d;

    logic ex_live, mem_live, issue;

    // Operand 0 is source A, operand 1 is source B (store data for stores).
    logic [1:0][REGW-1:0] op_rs;
    logic [1:0]           op_use;
    logic [1:0]           hit1;
    logic [1:0]           hit2;

    assign op_rs[0]  = id_rs_a;
    assign op_rs[1]  = id_rs_b;
    assign op_use[0] = id_use_a;
    assign op_use[1] = id_use_b;

    // rd==0 never counts as live, so an r0 source can never match.
    assign ex_live  = ex_wr_q && (ex_rd_q != '0);
    assign mem_live = mem_wr_q && (mem_rd_q != '0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit1[gi] = op_use[gi] && (op_rs[gi] == ex_rd_q) && ex_live;
            assign hit2[gi] = op_use[gi] && (op_rs[gi] == mem_rd_q) && mem_live;
        end
    endgenerate

    // Store data produced by a load in EX is picked up later via mw_one.
    assign stall = id_valid && !flush && ex_load_q && (hit1[0] || (hit1[1] && !id_store));
    assign issue = id_valid && !stall && !flush;

    always_comb begin
        ex_rd_d   = issue ? id_rd   : '0;
        ex_wr_d   = issue && id_wr;
        ex_load_d = issue && id_load;

        one_a_d  = issue && hit1[0];
        two_a_d  = issue && hit2[0] && !hit1[0];
        one_b_d  = issue && !id_store && hit1[1];
        two_b_d  = issue && !id_store && hit2[1] && !hit1[1];
        mw_one_d = issue && id_store && hit1[1];
        mw_two_d = issue && id_store && hit2[1] && !hit1[1];

        count_d = count_q;
        if (stall && (count_q != '1)) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd_q   <= '0;
            ex_wr_q   <= 1'b0;
            ex_load_q <= 1'b0;
            mem_rd_q  <= '0;
            mem_wr_q  <= 1'b0;
            one_a_q   <= 1'b0;
            two_a_q   <= 1'b0;
            one_b_q   <= 1'b0;
            two_b_q   <= 1'b0;
            mw_one_q  <= 1'b0;
            mw_two_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            mem_rd_q  <= ex_rd_q;
            mem_wr_q  <= ex_wr_q;
            ex_rd_q   <= ex_rd_d;
            ex_wr_q   <= ex_wr_d;
            ex_load_q <= ex_load_d;
            one_a_q   <= one_a_d;
            two_a_q   <= two_a_d;
            one_b_q   <= one_b_d;
            two_b_q   <= two_b_d;
            mw_one_q  <= mw_one_d;
            mw_two_q  <= mw_two_d;
            count_q   <= count_d;
        end
    end

    assign one_a       = one_a_q;
    assign two_a       = two_a_q;
    assign one_b       = one_b_q;
    assign two_b       = two_b_q;
    assign mw_one      = mw_one_q;
    assign mw_two      = mw_two_q;
    assign stall_count = count_q;

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Decode-stage hazard controller for the 16-bit, 8-register pipeline. It tracks the destination registers of the instructions in EX and MEM and compares them against the source registers of the instruction in ID. It registers the forwarding selects (`one_a`, `one_b`, `two_a`, `two_b`, `mw_one`, `mw_two`) that drive the downstream forwarding mux during the consuming instruction's EX cycle. It also raises a one-cycle load-use stall and counts stall cycles.

## Interface
- `REGW`, 3, register-address width (8 registers; r0 reads as zero)
- `CNTW`, 16, stall-counter width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous and active-high
- `id_valid` in 1: ID holds a real instruction
- `id_rs_a` in REGW: source A register
- `id_rs_b` in REGW: source B register (store data register for stores)
- `id_use_a` in 1: instruction reads rs_a
- `id_use_b` in 1: instruction reads rs_b
- `id_rd` in REGW: destination register
- `id_wr` in 1: instruction writes rd
- `id_load` in 1: instruction is a load
- `id_store` in 1: instruction is a store
- `flush` in 1: squash the instruction in ID (branch taken in EX)
- `stall` out 1: combinational; hold PC/IF/ID this cycle
- `one_a`, `one_b`, `two_a`, `two_b` out 1 each: registered ALU-operand forwarding selects
- `mw_one`, `mw_two` out 1 each: registered store-data forwarding selects
- `stall_count` out CNTW: saturating count of stall cycles

## Operation
- History registers: `ex_{rd,wr,load}` holds the instruction now in EX; `mem_{rd,wr}` holds the instruction now in MEM.
- A history entry is live only when its wr=1 and rd≠0. A bubble has wr=0 and load=0.
- `issue = id_valid & ~stall & ~flush`.
- Every edge, the pipeline advances unconditionally:
  - `mem_* <= ex_*`
  - `ex_* <= issue ? id fields : bubble`
- Hit terms:
  - `hitA1 = use_a & rs_a==ex_rd & ex live`
  - `hitA2 = use_a & rs_a==mem_rd & mem live`
  - `hitB1`, `hitB2` are the same terms for rs_b.
- Load-use stall: `stall = id_valid & ~flush & ex_load & (hitA1 | (hitB1 & ~id_store))`.
  - A store whose data register depends on a load in EX does not stall; `mw_one` covers it.
- Registered selects, updated every edge. All are 0 when `~issue`. Otherwise:
  - `one_a <= hitA1`
  - `two_a <= hitA2 & ~hitA1` (the youngest producer wins)
  - Non-store instructions: `one_b <= hitB1`, `two_b <= hitB2 & ~hitB1`, `mw_one = mw_two = 0`.
  - Stores: `mw_one <= hitB1`, `mw_two <= hitB2 & ~hitB1`, `one_b = two_b = 0`.
- Stall counter:
  - `stall_count <= stall_count + 1` on each cycle with `stall=1`.
  - Saturates at 2^CNTW−1. It is never wrapped.
- Stall state sequence: an instruction in ID that depends on a load waits exactly one cycle. The load then moves to MEM and the dependency is served by `two_*`. There is never a second consecutive stall for the same pair.
- Flush and stall in the same cycle: flush wins. `stall=0`, a bubble enters EX, and the counter does not increment.
- r0 as a source never produces a hit, even when r0 is in the history.

## Timing
- Reset (edge with `rst=1`):
  - All history entries become bubbles.
  - `one_a`, `one_b`, `two_a`, `two_b`, `mw_one`, `mw_two` = 0.
  - `stall_count` = 0.
  - `stall` = 0 in the cycle after reset, because history holds bubbles.
- Reset asserted mid-stall clears history, so a stalled instruction re-evaluates against empty history after reset.
- Select latency: an instruction issued at edge N has its selects valid during cycle N..N+1, which is its EX cycle.
- `stall` is combinational from ID inputs and registers in the same cycle. It has no output register.
- An ID instruction held by `stall` is re-evaluated the next cycle against the advanced history.

## Test plan
- Back-to-back ALU: `add r3←r1,r2` then `add r4←r3,r3`.
  - Expect in the consumer's EX cycle: `one_a=one_b=1`, `two_*=0`, `stall=0`.
- Distance two: `add r5←…`, `nop`, `sub r6←r5,r7`.
  - Expect `two_a=1`, `one_a=0`, `two_b=0`.
- Load-use: `ld r2←[r1]` then `add r3←r2,r4`.
  - Expect `stall=1` for exactly 1 cycle and `stall_count` 0→1.
  - The add then issues with `two_a=1`, `one_a=0`.
- Store after load: `ld r2` then `st r2→[r6]`.
  - Expect `stall=0`, `mw_one=1`, `one_b=0`.
  - Expect a dependency on r6 as rs_a with a live EX producer to give `one_a=1`.
- Double producer and r0: `add r1←…`, `add r1←…`, `add r2←r1,r0`.
  - Expect `one_a=1`, `two_a=0`.
  - Expect the B operand (r0) to produce no forward even after an `add r0←…` in history.
- Flush during stall and reset:
  - Load-use pair with `flush=1` in the stall cycle: `stall=0`, the counter is unchanged, and all selects are 0 next cycle.
  - `rst` pulse mid-sequence: all outputs 0 and the counter is 0.
  - Preloading the counter near the maximum through forced stalls: the counter holds at 0xFFFF.
